// File: rtl/lisa_qspi_target.sv
// lisa_qspi_target: SPI/QSPI memory-side responder for the LISA QSPI master.
// The SPI pins are oversampled in the clk domain, the opcode is decoded, and
// address and data are shifted over sio[3:0]. Traffic becomes single-byte
// read/write strobes on a local memory port. Reads stream by prefetching the
// next byte as soon as the current byte's first bit or nibble is driven.
module lisa_qspi_target #(
   parameter int          ADDR_BITS   = 24,
   parameter int          DUMMY_QUAD  = 6,
   parameter logic [7:0]  QUAD_WR_CMD = 8'h38
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 spi_sclk_i,
   input  logic                 spi_cs_n_i,
   input  logic [3:0]           sio_i,
   output logic [3:0]           sio_o,
   output logic [3:0]           sio_oe,
   output logic [ADDR_BITS-1:0] mem_addr,
   output logic [7:0]           mem_wdata,
   output logic                 mem_we,
   output logic                 mem_re,
   input  logic [7:0]           mem_rdata,
   output logic                 wren_latch,
   output logic                 busy
);

   localparam logic [2:0] S_IDLE   = 3'd0;
   localparam logic [2:0] S_CMD    = 3'd1;
   localparam logic [2:0] S_ADDR   = 3'd2;
   localparam logic [2:0] S_DUMMY  = 3'd3;
   localparam logic [2:0] S_RDATA  = 3'd4;
   localparam logic [2:0] S_WDATA  = 3'd5;
   localparam logic [2:0] S_IGNORE = 3'd6;

   localparam int CNT_W = 6;
   localparam logic [CNT_W-1:0] CMD_LAST       = CNT_W'(7);
   localparam logic [CNT_W-1:0] ADDR_LAST_SER  = CNT_W'(ADDR_BITS - 1);
   localparam logic [CNT_W-1:0] ADDR_LAST_QUAD = CNT_W'(ADDR_BITS / 4 - 1);
   localparam logic [CNT_W-1:0] DUMMY_LAST     = CNT_W'(DUMMY_QUAD - 1);
   localparam logic [CNT_W-1:0] BYTE_LAST_SER  = CNT_W'(7);
   localparam logic [CNT_W-1:0] BYTE_LAST_QUAD = CNT_W'(1);
   localparam logic [CNT_W-1:0] CNT_ZERO       = '0;

   // Synchronizer stages: _p0/_p1 resynchronize, _p2 holds the previous value for edge detect
   logic       sclk_p0, sclk_p1, sclk_p2;
   logic       cs_n_p0, cs_n_p1, cs_n_p2;
   logic [3:0] sio_p0, sio_p1;

   logic [2:0]           state;
   logic [CNT_W-1:0]     unit_cnt;
   logic                 quad_mode;
   logic                 rd_cmd;
   logic                 wr_done;
   logic                 vld_p1;

   logic [6:0]           cmd_sr;
   logic [ADDR_BITS-2:0] addr_sr;
   logic [6:0]           wr_sr;
   logic [7:0]           out_sr;
   logic [7:0]           rd_buf;

   logic                 sclk_rise, sclk_fall, cs_hi, cs_fall;
   logic [7:0]           cmd_nxt;
   logic [ADDR_BITS-1:0] addr_nxt;
   logic [7:0]           wr_nxt;
   logic [7:0]           rd_src;
   logic [CNT_W-1:0]     addr_last, byte_last, unit_cnt_inc;

   // Pin synchronizers; the cs chain resets to "asserted" so only a genuine new fall starts a command
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sclk_p0 <= 1'b0;
         sclk_p1 <= 1'b0;
         sclk_p2 <= 1'b0;
         cs_n_p0 <= 1'b0;
         cs_n_p1 <= 1'b0;
         cs_n_p2 <= 1'b0;
         sio_p0  <= 4'h0;
         sio_p1  <= 4'h0;
      end else begin
         sclk_p0 <= spi_sclk_i;
         sclk_p1 <= sclk_p0;
         sclk_p2 <= sclk_p1;
         cs_n_p0 <= spi_cs_n_i;
         cs_n_p1 <= cs_n_p0;
         cs_n_p2 <= cs_n_p1;
         sio_p0  <= sio_i;
         sio_p1  <= sio_p0;
      end
   end

   // Edge detection and next-value shifter contents for the current sclk edge
   always_comb begin
      sclk_rise    = sclk_p1 & ~sclk_p2;
      sclk_fall    = ~sclk_p1 & sclk_p2;
      cs_hi        = cs_n_p1;
      cs_fall      = ~cs_n_p1 & cs_n_p2;
      cmd_nxt      = {cmd_sr, sio_p1[0]};
      addr_nxt     = quad_mode ? {addr_sr[ADDR_BITS-5:0], sio_p1} : {addr_sr, sio_p1[0]};
      wr_nxt       = quad_mode ? {wr_sr[3:0], sio_p1} : {wr_sr, sio_p1[0]};
      rd_src       = (unit_cnt == CNT_ZERO) ? rd_buf : out_sr;
      addr_last    = quad_mode ? ADDR_LAST_QUAD : ADDR_LAST_SER;
      byte_last    = quad_mode ? BYTE_LAST_QUAD : BYTE_LAST_SER;
      unit_cnt_inc = unit_cnt + CNT_W'(1);
   end

   // Data shifters: contents are only meaningful while their state is active, so no reset
   always_ff @(posedge clk) begin
      if (sclk_rise && state == S_CMD)   cmd_sr  <= cmd_nxt[6:0];
      if (sclk_rise && state == S_ADDR)  addr_sr <= addr_nxt[ADDR_BITS-2:0];
      if (sclk_rise && state == S_WDATA) wr_sr   <= wr_nxt[6:0];
      if (sclk_fall && state == S_RDATA)
         out_sr <= quad_mode ? {rd_src[3:0], 4'h0} : {rd_src[6:0], 1'b0};
      if (vld_p1) rd_buf <= mem_rdata;
   end

   // Command FSM, memory strobes and pad drive; a deasserted cs overrides any same-cycle sclk edge
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state      <= S_IDLE;
         unit_cnt   <= CNT_ZERO;
         quad_mode  <= 1'b0;
         rd_cmd     <= 1'b0;
         wr_done    <= 1'b0;
         vld_p1     <= 1'b0;
         sio_o      <= 4'h0;
         sio_oe     <= 4'h0;
         mem_addr   <= '0;
         mem_wdata  <= 8'h00;
         mem_we     <= 1'b0;
         mem_re     <= 1'b0;
         wren_latch <= 1'b0;
         busy       <= 1'b0;
      end else begin
         mem_re <= 1'b0;
         mem_we <= 1'b0;
         vld_p1 <= mem_re;
         if (mem_we) mem_addr <= mem_addr + ADDR_BITS'(1);
         if (cs_hi) begin
            if (wr_done) wren_latch <= 1'b0;
            state    <= S_IDLE;
            unit_cnt <= CNT_ZERO;
            wr_done  <= 1'b0;
            sio_o    <= 4'h0;
            sio_oe   <= 4'h0;
            busy     <= 1'b0;
         end else begin
            case (state)
               S_IDLE: begin
                  if (cs_fall) begin
                     state     <= S_CMD;
                     busy      <= 1'b1;
                     unit_cnt  <= CNT_ZERO;
                     quad_mode <= 1'b0;
                     wr_done   <= 1'b0;
                  end
               end
               S_CMD: begin
                  if (sclk_rise) begin
                     unit_cnt <= unit_cnt_inc;
                     if (unit_cnt == CMD_LAST) begin
                        unit_cnt <= CNT_ZERO;
                        if (cmd_nxt == 8'h03) begin
                           state <= S_ADDR; quad_mode <= 1'b0; rd_cmd <= 1'b1;
                        end else if (cmd_nxt == 8'h02) begin
                           state <= S_ADDR; quad_mode <= 1'b0; rd_cmd <= 1'b0;
                        end else if (cmd_nxt == 8'hEB) begin
                           state <= S_ADDR; quad_mode <= 1'b1; rd_cmd <= 1'b1;
                        end else if (cmd_nxt == QUAD_WR_CMD) begin
                           state <= S_ADDR; quad_mode <= 1'b1; rd_cmd <= 1'b0;
                        end else if (cmd_nxt == 8'h06) begin
                           state <= S_IGNORE; wren_latch <= 1'b1;
                        end else begin
                           state <= S_IGNORE;
                        end
                     end
                  end
               end
               S_ADDR: begin
                  if (sclk_rise) begin
                     unit_cnt <= unit_cnt_inc;
                     if (unit_cnt == addr_last) begin
                        unit_cnt <= CNT_ZERO;
                        mem_addr <= addr_nxt;
                        if (!rd_cmd) begin
                           state <= S_WDATA;
                        end else if (quad_mode && DUMMY_QUAD != 0) begin
                           state <= S_DUMMY;
                        end else begin
                           state  <= S_RDATA;
                           mem_re <= 1'b1;
                           sio_oe <= quad_mode ? 4'b1111 : 4'b0010;
                        end
                     end
                  end
               end
               S_DUMMY: begin
                  if (sclk_rise) begin
                     unit_cnt <= unit_cnt_inc;
                     if (unit_cnt == DUMMY_LAST) begin
                        unit_cnt <= CNT_ZERO;
                        state    <= S_RDATA;
                        mem_re   <= 1'b1;
                        sio_oe   <= 4'b1111;
                     end
                  end
               end
               S_RDATA: begin
                  if (sclk_fall) begin
                     if (unit_cnt == CNT_ZERO) begin
                        mem_re   <= 1'b1;
                        mem_addr <= mem_addr + ADDR_BITS'(1);
                     end
                     sio_o    <= quad_mode ? rd_src[7:4] : {2'b00, rd_src[7], 1'b0};
                     unit_cnt <= (unit_cnt == byte_last) ? CNT_ZERO : unit_cnt_inc;
                  end
               end
               S_WDATA: begin
                  if (sclk_rise) begin
                     unit_cnt <= unit_cnt_inc;
                     if (unit_cnt == byte_last) begin
                        unit_cnt  <= CNT_ZERO;
                        mem_we    <= 1'b1;
                        mem_wdata <= wr_nxt;
                        wr_done   <= 1'b1;
                     end
                  end
               end
               S_IGNORE: begin
                  sio_oe <= 4'h0;
               end
               default: begin
                  state <= S_IDLE;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_lisa_qspi_target.sv
// Directed bench for lisa_qspi_target: drives a mode-0 SPI/QSPI master and
// models a byte memory with one-clock read latency.
module tb_lisa_qspi_target;

   localparam int HALF = 6;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        spi_sclk_i;
   logic        spi_cs_n_i;
   logic [3:0]  sio_i;
   logic [3:0]  sio_o;
   logic [3:0]  sio_oe;
   logic [23:0] mem_addr;
   logic [7:0]  mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic [7:0]  mem_rdata = 8'h00;
   logic        wren_latch;
   logic        busy;

   logic [7:0]  mem [0:255];
   logic [23:0] re_q[$];
   logic [23:0] we_a_q[$];
   logic [7:0]  we_d_q[$];
   int          both_cnt = 0;
   int          total = 0;
   int          bad = 0;

   lisa_qspi_target dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .spi_sclk_i (spi_sclk_i),
      .spi_cs_n_i (spi_cs_n_i),
      .sio_i      (sio_i),
      .sio_o      (sio_o),
      .sio_oe     (sio_oe),
      .mem_addr   (mem_addr),
      .mem_wdata  (mem_wdata),
      .mem_we     (mem_we),
      .mem_re     (mem_re),
      .mem_rdata  (mem_rdata),
      .wren_latch (wren_latch),
      .busy       (busy)
   );

   always #5 clk = ~clk;

   // Memory model: read data appears one clock after the strobe
   always @(posedge clk) begin
      if (mem_re) mem_rdata <= mem[mem_addr[7:0]];
   end

   // Strobe log, sampled mid-cycle
   always @(negedge clk) begin
      if (mem_re) re_q.push_back(mem_addr);
      if (mem_we) begin
         we_a_q.push_back(mem_addr);
         we_d_q.push_back(mem_wdata);
      end
      if (mem_re && mem_we) both_cnt++;
   end

   initial begin
      #2_000_000;
      $display("FAIL watchdog observed=timeout expected=finish");
      $fatal(1, "watchdog");
   end

   task automatic tick(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] re_at(input int i);
      if (i < re_q.size()) return 32'(re_q[i]);
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] wa_at(input int i);
      if (i < we_a_q.size()) return 32'(we_a_q[i]);
      return 32'hFFFF_FFFF;
   endfunction

   function automatic logic [31:0] wd_at(input int i);
      if (i < we_d_q.size()) return 32'(we_d_q[i]);
      return 32'hFFFF_FFFF;
   endfunction

   // n sclk cycles, MSB/high nibble first; samples sio_o and sio_oe at each rise
   task automatic xfer(input logic [31:0] v, input int n, input bit quad, input bit end_cs,
                       output logic [31:0] rx, output logic [3:0] oe_or, output logic [3:0] oe_and);
      rx = 32'h0;
      oe_or = 4'h0;
      oe_and = 4'hF;
      for (int i = 0; i < n; i++) begin
         if (quad) sio_i = v[4*(n-1-i) +: 4];
         else      sio_i = {3'b000, v[n-1-i]};
         tick(HALF);
         spi_sclk_i = 1'b1;
         rx = quad ? {rx[27:0], sio_o} : {rx[30:0], sio_o[1]};
         oe_or  = oe_or | sio_oe;
         oe_and = oe_and & sio_oe;
         tick(HALF);
         spi_sclk_i = 1'b0;
         if (end_cs && i == n - 1) spi_cs_n_i = 1'b1;
      end
      sio_i = 4'h0;
   endtask

   initial begin
      logic [31:0] rx;
      logic [3:0]  oo, oa, oo2, oa2;
      int          rb, wb;

      for (int i = 0; i < 256; i++) mem[i] = 8'(i) ^ 8'hA5;
      mem[8'h10] = 8'h5A;
      mem[8'h11] = 8'hC3;
      mem[8'h20] = 8'h3C;
      mem[8'hFF] = 8'h96;

      rst_n = 1'b0;
      spi_cs_n_i = 1'b1;
      spi_sclk_i = 1'b0;
      sio_i = 4'h0;
      tick(4);
      rst_n = 1'b1;
      tick(4);
      chk("rst_oe", 32'(sio_oe), 32'h0);
      chk("rst_sio_o", 32'(sio_o), 32'h0);
      chk("rst_busy", 32'(busy), 32'h0);
      chk("rst_addr", 32'(mem_addr), 32'h0);
      chk("rst_wren", 32'(wren_latch), 32'h0);
      chk("rst_strobes", 32'({mem_re, mem_we}), 32'h0);

      // 1: serial read 0x10, two bytes; last fall coincides with cs rise
      rb = re_q.size();
      spi_cs_n_i = 1'b0;
      tick(HALF);
      xfer(32'h03, 8, 1'b0, 1'b0, rx, oo, oa);
      chk("t1_busy", 32'(busy), 32'h1);
      xfer(32'h000010, 24, 1'b0, 1'b0, rx, oo, oa);
      chk("t1_addr_oe", 32'(oo), 32'h0);
      xfer(32'h0, 16, 1'b0, 1'b1, rx, oo, oa);
      chk("t1_data", rx, 32'h5AC3);
      chk("t1_oe_and", 32'(oa), 32'h2);
      chk("t1_oe_or", 32'(oo), 32'h2);
      tick(8);
      chk("t1_oe_end", 32'(sio_oe), 32'h0);
      chk("t1_busy_end", 32'(busy), 32'h0);
      chk("t1_re_cnt", 32'(re_q.size() - rb), 32'd3);
      chk("t1_re0", re_at(rb), 32'h10);
      chk("t1_re1", re_at(rb + 1), 32'h11);
      chk("t1_re2", re_at(rb + 2), 32'h12);

      // 2: quad write 0x100 <- AB, CD
      wb = we_a_q.size();
      rb = re_q.size();
      spi_cs_n_i = 1'b0;
      tick(HALF);
      xfer(32'h38, 8, 1'b0, 1'b0, rx, oo, oa);
      xfer(32'h000100, 6, 1'b1, 1'b0, rx, oo, oa);
      xfer(32'hABCD, 4, 1'b1, 1'b1, rx, oo2, oa2);
      tick(8);
      chk("t2_oe", 32'(oo | oo2), 32'h0);
      chk("t2_we_cnt", 32'(we_a_q.size() - wb), 32'd2);
      chk("t2_wa0", wa_at(wb), 32'h100);
      chk("t2_wd0", wd_at(wb), 32'hAB);
      chk("t2_wa1", wa_at(wb + 1), 32'h101);
      chk("t2_wd1", wd_at(wb + 1), 32'hCD);
      chk("t2_no_re", 32'(re_q.size() - rb), 32'd0);

      // 3: quad read 0x20 with dummy cycles
      rb = re_q.size();
      spi_cs_n_i = 1'b0;
      tick(HALF);
      xfer(32'hEB, 8, 1'b0, 1'b0, rx, oo, oa);
      xfer(32'h000020, 6, 1'b1, 1'b0, rx, oo, oa);
      xfer(32'h0, 6, 1'b1, 1'b0, rx, oo2, oa2);
      chk("t3_addr_oe", 32'(oo), 32'h0);
      chk("t3_dummy_oe", 32'(oo2), 32'h0);
      xfer(32'h0, 2, 1'b1, 1'b1, rx, oo, oa);
      chk("t3_data", rx, 32'h3C);
      chk("t3_oe", 32'(oa), 32'hF);
      tick(8);
      chk("t3_re_cnt", 32'(re_q.size() - rb), 32'd2);
      chk("t3_re0", re_at(rb), 32'h20);
      chk("t3_re1", re_at(rb + 1), 32'h21);

      // 4: WREN, then serial write 0x40 <- 77 clears the latch at cs rise
      wb = we_a_q.size();
      spi_cs_n_i = 1'b0;
      tick(HALF);
      xfer(32'h03, 7, 1'b0, 1'b0, rx, oo, oa);
      chk("t4_wren_early", 32'(wren_latch), 32'h0);
      xfer(32'h0, 1, 1'b0, 1'b0, rx, oo, oa);
      chk("t4_wren_set", 32'(wren_latch), 32'h1);
      tick(HALF);
      spi_cs_n_i = 1'b1;
      tick(8);
      chk("t4_wren_hold", 32'(wren_latch), 32'h1);
      spi_cs_n_i = 1'b0;
      tick(HALF);
      xfer(32'h02, 8, 1'b0, 1'b0, rx, oo, oa);
      xfer(32'h000040, 24, 1'b0, 1'b0, rx, oo, oa);
      xfer(32'h77, 8, 1'b0, 1'b0, rx, oo2, oa2);
      tick(2);
      chk("t4_wr_oe", 32'(oo | oo2), 32'h0);
      chk("t4_wren_mid", 32'(wren_latch), 32'h1);
      spi_cs_n_i = 1'b1;
      tick(2);
      chk("t4_wren_sync", 32'(wren_latch), 32'h1);
      tick(1);
      chk("t4_wren_clr", 32'(wren_latch), 32'h0);
      chk("t4_busy_clr", 32'(busy), 32'h0);
      tick(6);
      chk("t4_we_cnt", 32'(we_a_q.size() - wb), 32'd1);
      chk("t4_wa", wa_at(wb), 32'h40);
      chk("t4_wd", wd_at(wb), 32'h77);

      // 5: aborted partial write byte, then unknown opcode 9F
      wb = we_a_q.size();
      rb = re_q.size();
      spi_cs_n_i = 1'b0;
      tick(HALF);
      xfer(32'h02, 8, 1'b0, 1'b0, rx, oo, oa);
      xfer(32'h000050, 24, 1'b0, 1'b0, rx, oo, oa);
      xfer(32'hA, 4, 1'b0, 1'b1, rx, oo, oa);
      tick(8);
      chk("t5_no_we", 32'(we_a_q.size() - wb), 32'd0);
      spi_cs_n_i = 1'b0;
      tick(HALF);
      xfer(32'h9F, 8, 1'b0, 1'b0, rx, oo, oa);
      xfer(32'h55, 8, 1'b0, 1'b1, rx, oo2, oa2);
      chk("t5_ign_oe", 32'(oo | oo2), 32'h0);
      tick(8);
      chk("t5_busy_end", 32'(busy), 32'h0);
      chk("t5_no_re", 32'(re_q.size() - rb), 32'd0);
      chk("t5_wren", 32'(wren_latch), 32'h0);

      // 6: read wraps from all-ones to 0; reset mid-byte aborts the transfer
      rb = re_q.size();
      wb = we_a_q.size();
      spi_cs_n_i = 1'b0;
      tick(HALF);
      xfer(32'h03, 8, 1'b0, 1'b0, rx, oo, oa);
      xfer(32'hFFFFFF, 24, 1'b0, 1'b0, rx, oo, oa);
      xfer(32'h0, 4, 1'b0, 1'b0, rx, oo, oa);
      chk("t6_nibble", rx, 32'h9);
      rst_n = 1'b0;
      tick(1);
      chk("t6_rst_oe", 32'(sio_oe), 32'h0);
      chk("t6_rst_busy", 32'(busy), 32'h0);
      xfer(32'h0, 4, 1'b0, 1'b0, rx, oo, oa);
      rst_n = 1'b1;
      xfer(32'h0, 8, 1'b0, 1'b0, rx, oo2, oa2);
      chk("t6_post_oe", 32'(oo | oo2), 32'h0);
      chk("t6_post_busy", 32'(busy), 32'h0);
      spi_cs_n_i = 1'b1;
      tick(8);
      chk("t6_re_cnt", 32'(re_q.size() - rb), 32'd2);
      chk("t6_re0", re_at(rb), 32'hFFFFFF);
      chk("t6_re1", re_at(rb + 1), 32'h0);
      chk("t6_no_we", 32'(we_a_q.size() - wb), 32'd0);
      chk("t6_addr", 32'(mem_addr), 32'h0);
      chk("re_we_overlap", 32'(both_cnt), 32'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
